// File: rtl/wishbone_pkg.sv
// ----------------------------------------------------------------------------
// wishbone_pkg
// Shared definitions for the single-transfer Wishbone B4 pipelined initiator:
//   - wb_state_e     : initiator FSM state encoding (2 bits)
//   - WB_ADR_W       : byte address width
//   - WB_DAT_W       : data width
//   - WB_SEL_W       : byte-select width
//   - WB_TIMEOUT_DEF : default abort timeout in cycles (timeout build only)
// ----------------------------------------------------------------------------
package wishbone_pkg;

    localparam int unsigned WB_ADR_W       = 32;
    localparam int unsigned WB_DAT_W       = 32;
    localparam int unsigned WB_SEL_W       = 4;
    localparam int unsigned WB_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RESPONSE = 2'd3
    } wb_state_e;

endpackage : wishbone_pkg

// File: rtl/wishbone_timeout_counter.sv
// ----------------------------------------------------------------------------
// wishbone_timeout_counter
// Counts cycles a bus transfer has been outstanding and flags the cycle in
// which the transfer has used up its TIMEOUT_CYCLES budget. Only instantiated
// by wishbone_master when WISHBONE_MASTER_TIMEOUT_EN is defined.
// Ports:
//   clk_i     in  clock
//   rst_i     in  synchronous active-low reset
//   clear_i   in  restart the count (transfer accepted)
//   enable_i  in  transfer outstanding this cycle; count advances
//   expired_o out high in the last allowed cycle of an outstanding transfer
// ----------------------------------------------------------------------------
module wishbone_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at TIMEOUT_CYCLES so a stuck enable can never wrap around.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count reads k-1 during the k-th outstanding cycle, so the edge that
    // would bring it to TIMEOUT_CYCLES is the abort edge.
    assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule : wishbone_timeout_counter

// File: rtl/wishbone_master.sv
// ----------------------------------------------------------------------------
// wishbone_master
// Single-transfer Wishbone B4 pipelined initiator. One client request becomes
// one bus cycle; the result comes back as a one-cycle rsp_valid_o pulse.
// Optional feature macro: WISHBONE_MASTER_TIMEOUT_EN - aborts a transfer that
// has been outstanding for TIMEOUT_CYCLES cycles and reports rsp_err_o=1.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   req_i/req_*_i           client request (address, write enable, data, sel)
//   req_ready_o             high in IDLE; request taken when req_i && ready
//   rsp_valid_o/rsp_dat_o   response pulse and held read data
//   rsp_err_o               transfer aborted by timeout (with rsp_valid_o)
//   wb_*_o                  registered Wishbone initiator outputs
//   wb_dat_i/ack_i/stall_i  Wishbone responder inputs
// ----------------------------------------------------------------------------
module wishbone_master
    import wishbone_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [WB_ADR_W-1:0] req_adr_i,
    input  logic                req_we_i,
    input  logic [WB_DAT_W-1:0] req_dat_i,
    input  logic [WB_SEL_W-1:0] req_sel_i,
    output logic                req_ready_o,
    output logic                rsp_valid_o,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    output logic [WB_SEL_W-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_stall_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wishbone_master: TIMEOUT_CYCLES must be at least 2");
    end

    wb_state_e           state_q, state_d;
    logic [WB_ADR_W-1:0] adr_q, adr_d;
    logic [WB_DAT_W-1:0] dat_q, dat_d;
    logic [WB_SEL_W-1:0] sel_q, sel_d;
    logic                we_q, we_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;

    logic accept;
    logic ack_ok;
    logic timeout_expired;

    // A request is only taken in IDLE; req_i is ignored everywhere else.
    assign accept = (state_q == ST_IDLE) && req_i;

    // An ack only counts once the strobe has been taken (no stall) or while
    // waiting for it; acks in IDLE/RESPONSE are spurious and dropped.
    assign ack_ok = wb_ack_i &&
                    (((state_q == ST_REQUEST) && !wb_stall_i) ||
                     (state_q == ST_WAIT_ACK));

`ifdef WISHBONE_MASTER_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;

    wishbone_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (accept),
        .enable_i  (wb_cyc_o),
        .expired_o (timeout_expired)
    );

    always_comb begin
        rsp_err_d = rsp_err_q;
        if (accept) begin
            rsp_err_d = 1'b0;
        end else if (timeout_expired && !ack_ok) begin
            // An ack on the expiry edge wins; only a real miss is an error.
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err_o = rsp_err_q;
`else
    assign timeout_expired = 1'b0;
    assign rsp_err_o       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    adr_d   = req_adr_i;
                    dat_d   = req_dat_i;
                    sel_d   = req_sel_i;
                    we_d    = req_we_i;
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (ack_ok || timeout_expired) begin
                    state_d = ST_RESPONSE;
                end else if (!wb_stall_i) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_ok || timeout_expired) begin
                    state_d = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ack_ok && !we_q) begin
            rsp_dat_d = wb_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    // Control outputs are pure decodes of the registered state.
    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESPONSE);
    assign wb_cyc_o    = (state_q == ST_REQUEST) || (state_q == ST_WAIT_ACK);
    assign wb_stb_o    = (state_q == ST_REQUEST);
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule : wishbone_master

// File: tb/tb_wishbone_master.sv
// ----------------------------------------------------------------------------
// tb_wishbone_master
// Directed bench for wishbone_master. Cycle numbering follows the design:
// the accepting edge is edge 0 and "cycle k" is the interval after edge k-1.
// Outputs are sampled 1 time unit after each rising edge, inputs are changed
// right after sampling. Timeout scenarios run when WISHBONE_MASTER_TIMEOUT_EN
// is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wishbone_master;

    localparam int unsigned TO_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] req_adr_i;
    logic        req_we_i;
    logic [31:0] req_dat_i;
    logic [3:0]  req_sel_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stall_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wishbone_master #(
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .req_adr_i   (req_adr_i),
        .req_we_i    (req_we_i),
        .req_dat_i   (req_dat_i),
        .req_sel_i   (req_sel_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_stall_i  (wb_stall_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request and let edge 0 accept it; returns in cycle 1.
    task automatic issue(input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel);
        req_i = 1'b1; req_adr_i = adr; req_we_i = we; req_dat_i = dat; req_sel_i = sel;
        tick;
        req_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0; req_i = 1'b0; req_adr_i = '0; req_we_i = 1'b0; req_dat_i = '0;
        req_sel_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        tick; tick;
        rst_i = 1'b1;
        n_vec++; if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got cyc/stb/we/valid/err=%b required 00000",
                              {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o}); end
        n_vec++; if ({wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat_o} !== 100'b0) begin
            n_err++; $display("FAIL reset_data: got adr=%h dat=%h sel=%h rsp_dat=%h required all 0",
                              wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat_o); end
        n_vec++; if (req_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b required 1", req_ready_o); end
        $display("reset: done");
    endtask

    task automatic test_read;
        issue(32'h0000_0004, 1'b0, 32'h0, 4'hF);
        // cycle 1: REQUEST
        n_vec++; if ({wb_cyc_o, wb_stb_o, req_ready_o, wb_we_o} !== 4'b1100) begin
            n_err++; $display("FAIL read_c1_ctrl: got cyc/stb/ready/we=%b required 1100",
                              {wb_cyc_o, wb_stb_o, req_ready_o, wb_we_o}); end
        n_vec++; if (wb_adr_o !== 32'h0000_0004) begin
            n_err++; $display("FAIL read_adr: got %h required 00000004", wb_adr_o); end
        tick;
        // cycle 2: WAIT_ACK, responder acks
        n_vec++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o} !== 3'b100) begin
            n_err++; $display("FAIL read_c2_ctrl: got cyc/stb/valid=%b required 100",
                              {wb_cyc_o, wb_stb_o, rsp_valid_o}); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        // cycle 3: RESPONSE
        n_vec++; if ({rsp_valid_o, rsp_err_o, wb_cyc_o} !== 3'b100) begin
            n_err++; $display("FAIL read_c3_rsp: got valid/err/cyc=%b required 100",
                              {rsp_valid_o, rsp_err_o, wb_cyc_o}); end
        n_vec++; if (rsp_dat_o !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL read_data: got %h required deadbeef", rsp_dat_o); end
        tick;
        // cycle 4: back in IDLE
        n_vec++; if ({req_ready_o, rsp_valid_o} !== 2'b10) begin
            n_err++; $display("FAIL read_c4_idle: got ready/valid=%b required 10",
                              {req_ready_o, rsp_valid_o}); end
        $display("read adr=00000004 rsp_dat=%h err=%b", rsp_dat_o, rsp_err_o);
    endtask

    task automatic test_write_stall;
        wb_dat_i = 32'hCAFE_F00D;
        issue(32'h0000_0008, 1'b1, 32'h1234_5678, 4'hF);
        wb_stall_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) wb_stall_i = 1'b0;
            n_vec++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin
                n_err++; $display("FAIL write_stb_c%0d: got cyc/stb/we=%b required 111",
                                  c, {wb_cyc_o, wb_stb_o, wb_we_o}); end
            n_vec++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== {32'h0000_0008, 32'h1234_5678, 4'hF}) begin
                n_err++; $display("FAIL write_stable_c%0d: got adr=%h dat=%h sel=%h required 00000008 12345678 f",
                                  c, wb_adr_o, wb_dat_o, wb_sel_o); end
            tick;
        end
        // cycle 5: WAIT_ACK
        n_vec++; if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin
            n_err++; $display("FAIL write_c5_ctrl: got cyc/stb=%b required 10", {wb_cyc_o, wb_stb_o}); end
        wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        // cycle 6: RESPONSE, read data untouched by a write
        n_vec++; if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin
            n_err++; $display("FAIL write_rsp: got valid/err=%b required 10", {rsp_valid_o, rsp_err_o}); end
        n_vec++; if (rsp_dat_o !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL write_keep_data: got %h required deadbeef", rsp_dat_o); end
        tick;
        $display("write adr=00000008 dat=12345678 stall=3 rsp_dat=%h", rsp_dat_o);
    endtask

    task automatic test_zero_wait;
        issue(32'h0000_0010, 1'b0, 32'h0, 4'h3);
        // cycle 1: REQUEST, immediate ack
        wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_5A5A;
        tick;
        // cycle 2: RESPONSE; a further ack here must be ignored
        wb_dat_i = 32'h1111_1111;
        n_vec++; if ({rsp_valid_o, wb_cyc_o} !== 2'b10) begin
            n_err++; $display("FAIL zw_c2_rsp: got valid/cyc=%b required 10", {rsp_valid_o, wb_cyc_o}); end
        n_vec++; if (rsp_dat_o !== 32'hA5A5_5A5A) begin
            n_err++; $display("FAIL zw_data: got %h required a5a55a5a", rsp_dat_o); end
        tick;
        wb_ack_i = 1'b0;
        n_vec++; if ({rsp_valid_o, req_ready_o, wb_cyc_o} !== 3'b010) begin
            n_err++; $display("FAIL zw_c3_single: got valid/ready/cyc=%b required 010",
                              {rsp_valid_o, req_ready_o, wb_cyc_o}); end
        n_vec++; if (rsp_dat_o !== 32'hA5A5_5A5A) begin
            n_err++; $display("FAIL zw_spurious_data: got %h required a5a55a5a", rsp_dat_o); end
        $display("zero-wait read adr=00000010 rsp_dat=%h", rsp_dat_o);
    endtask

    task automatic test_spurious_reset;
        wb_ack_i = 1'b1; wb_dat_i = 32'h2222_2222;
        tick; tick;
        wb_ack_i = 1'b0;
        n_vec++; if ({req_ready_o, wb_cyc_o, rsp_valid_o} !== 3'b100) begin
            n_err++; $display("FAIL spurious_state: got ready/cyc/valid=%b required 100",
                              {req_ready_o, wb_cyc_o, rsp_valid_o}); end
        n_vec++; if (rsp_dat_o !== 32'hA5A5_5A5A) begin
            n_err++; $display("FAIL spurious_data: got %h required a5a55a5a", rsp_dat_o); end
        issue(32'h0000_0020, 1'b0, 32'h0, 4'hF);
        tick;
        // cycle 2: WAIT_ACK, assert reset
        n_vec++; if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin
            n_err++; $display("FAIL rst_pre_wait: got cyc/stb=%b required 10", {wb_cyc_o, wb_stb_o}); end
        rst_i = 1'b0;
        tick;
        rst_i = 1'b1;
        n_vec++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, req_ready_o} !== 4'b0001) begin
            n_err++; $display("FAIL rst_mid: got cyc/stb/valid/ready=%b required 0001",
                              {wb_cyc_o, wb_stb_o, rsp_valid_o, req_ready_o}); end
        n_vec++; if ({wb_adr_o, rsp_dat_o} !== 64'h0) begin
            n_err++; $display("FAIL rst_mid_regs: got adr=%h rsp_dat=%h required 0 0", wb_adr_o, rsp_dat_o); end
        tick;
        n_vec++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            n_err++; $display("FAIL rst_after: got valid/ready=%b required 01", {rsp_valid_o, req_ready_o}); end
        $display("spurious ack + reset in WAIT_ACK: done");
    endtask

`ifdef WISHBONE_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int cyc_cnt;
        cyc_cnt = 0;
        issue(32'h0000_0030, 1'b0, 32'h0, 4'hF);
        for (int c = 1; c <= int'(TO_CYC); c++) begin
            if (wb_cyc_o === 1'b1) cyc_cnt++;
            tick;
        end
        n_vec++; if (cyc_cnt !== 16) begin
            n_err++; $display("FAIL to_cyc_len: got %0d cycles required 16", cyc_cnt); end
        // cycle 17: aborted response
        n_vec++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o} !== 4'b0011) begin
            n_err++; $display("FAIL to_abort: got cyc/stb/valid/err=%b required 0011",
                              {wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o}); end
        n_vec++; if (rsp_dat_o !== 32'h0) begin
            n_err++; $display("FAIL to_keep_data: got %h required 00000000", rsp_dat_o); end
        tick;
        $display("timeout read adr=00000030 err=1 expected");
    endtask

    task automatic test_timeout_ack_edge;
        issue(32'h0000_0034, 1'b0, 32'h0, 4'hF);
        for (int c = 1; c < int'(TO_CYC); c++) tick;
        // cycle 16: ack on the expiry edge
        n_vec++; if (wb_cyc_o !== 1'b1) begin
            n_err++; $display("FAIL to16_cyc: got %b required 1", wb_cyc_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D;
        tick;
        wb_ack_i = 1'b0;
        n_vec++; if ({rsp_valid_o, rsp_err_o} !== 2'b10) begin
            n_err++; $display("FAIL to16_rsp: got valid/err=%b required 10", {rsp_valid_o, rsp_err_o}); end
        n_vec++; if (rsp_dat_o !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL to16_data: got %h required 0badf00d", rsp_dat_o); end
        tick;
        $display("ack on expiry edge adr=00000034 rsp_dat=%h err=%b", rsp_dat_o, rsp_err_o);
    endtask
`endif

    initial begin
        test_reset;
        test_read;
        test_write_stall;
        test_zero_wait;
        test_spurious_reset;
`ifdef WISHBONE_MASTER_TIMEOUT_EN
        test_timeout;
        test_timeout_ack_edge;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_wishbone_master

// File: doc/wishbone_master.md
# wishbone_master

Single-transfer Wishbone B4 pipelined initiator that turns one client request (read or write) into one bus cycle and returns the result to the client. Sits between a processor-side access unit (instruction fetch or load/store) and any Wishbone responder, including the test-bench memory slave. Handles responder stall, waits for acknowledge, and optionally aborts hung transfers on a timeout.

## Interface
- TIMEOUT_CYCLES, 16: cycles allowed in REQUEST+WAIT_ACK before abort. Used only with the timeout feature; must be ≥2.
- clk_i  in  1  single clock; all logic on posedge.
- rst_i  in  1  reset, synchronous, active-low.
- req_i  in  1  client request strobe.
- req_adr_i  in  32  byte address.
- req_we_i  in  1  1 = write, 0 = read.
- req_dat_i  in  32  write data.
- req_sel_i  in  4  byte selects.
- req_ready_o  out  1  high only in IDLE; request accepted on posedge when req_i && req_ready_o.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_dat_o  out  32  read data, registered, held until next successful read.
- rsp_err_o  out  1  transfer aborted by timeout; valid with rsp_valid_o.
- wb_adr_o / wb_dat_o  out  32 / 32  registered address / write data.
- wb_sel_o  out  4  registered byte selects.
- wb_we_o, wb_stb_o, wb_cyc_o  out  1 each.
- wb_dat_i  in  32  responder read data.
- wb_ack_i, wb_stall_i  in  1 each.

## Operation
- States: IDLE, REQUEST, WAIT_ACK, RESPONSE. Encoded as a 2-bit enum.
- IDLE:
  - req_ready_o=1.
  - On accept, latch adr/we/dat/sel into wb_*_o registers and go to REQUEST.
- REQUEST:
  - cyc=1, stb=1.
  - If wb_stall_i=1, stay; stb and all wb_*_o remain stable.
  - If wb_stall_i=0 and wb_ack_i=1 (zero-wait responder), go to RESPONSE.
  - If wb_stall_i=0 and wb_ack_i=0, go to WAIT_ACK.
- WAIT_ACK:
  - cyc=1, stb=0.
  - On wb_ack_i go to RESPONSE.
- RESPONSE:
  - cyc=0, stb=0, rsp_valid_o=1 for exactly one cycle, then IDLE.
- Data capture: on the ack edge of a read, rsp_dat_o<=wb_dat_i. Writes leave rsp_dat_o unchanged.
- wb_ack_i is ignored in IDLE and RESPONSE (spurious ack): no state change, no data capture.
- req_i is ignored outside IDLE. The client must hold req_i high until accepted.
- Reset values: state=IDLE, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0. Consequently req_ready_o=1 after reset.
- Reset mid-transfer: returns to IDLE at that edge, cyc/stb drop, no rsp_valid_o is generated.

## Timing
- Non-stalled transfer with a one-cycle-latency responder: accept at edge 0; REQUEST in cycle 1; WAIT_ACK in cycle 2 (ack seen); rsp_valid_o in cycle 3; req_ready_o again in cycle 4.
- Each stall cycle adds one cycle. Each extra ack-wait cycle adds one cycle.
- Zero-wait responder (ack with stall=0 in REQUEST): rsp_valid_o in cycle 2.
- Throughput: at most one transfer per 3 cycles. No back-to-back pipelining.
- All outputs are registered or decoded from registered state; no combinational path from wb_*_i to wb_*_o.

## Configuration
- WISHBONE_MASTER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on accept and increments each cycle in REQUEST or WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES without ack, the transfer aborts: cyc=0, stb=0, go to RESPONSE with rsp_err_o=1, rsp_dat_o unchanged.
  - An ack arriving on the same edge as the timeout wins: normal completion, rsp_err_o=0.
- WISHBONE_MASTER_TIMEOUT_EN undefined: no counter, rsp_err_o tied 0, the master waits indefinitely.

## Structure
- Shared package wishbone_pkg holds:
  - the state enum typedef;
  - address, data and select width constants (32/32/4);
  - the default timeout constant.
- Optional sub-module wishbone_timeout_counter (clear, enable, expired output), instantiated only under WISHBONE_MASTER_TIMEOUT_EN. Everything else lives in one module.

## Test plan
- Read 0x00000004, responder returns 0xDEADBEEF with one-cycle ack, no stall -> stb high 1 cycle; rsp_valid_o in cycle 3; rsp_dat_o=0xDEADBEEF; rsp_err_o=0.
- Write 0x00000008 with data 0x12345678, sel 0xF, stall held 3 cycles -> stb high 4 cycles with adr/dat/sel stable; rsp_valid_o 1 cycle after ack; rsp_dat_o keeps its previous value.
- Zero-wait responder (ack with stall=0 in REQUEST) -> rsp_valid_o in cycle 2; exactly one rsp pulse.
- Spurious ack in IDLE, then rst_i=0 asserted during WAIT_ACK -> no state change on the spurious ack; after reset cyc=0, stb=0, no rsp_valid_o, req_ready_o=1.
- With WISHBONE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, responder never acks -> cyc drops after 16 cycles; rsp_valid_o=1 with rsp_err_o=1.
- Same setup, ack on the 16th cycle -> normal completion, rsp_err_o=0, data captured.
